// File: rtl/pkg_keccak.sv
// pkg_keccak: shared data width, sponge block size and arbiter state type
// for the two-requester keccak core arbiter.
package pkg_keccak;

    localparam int unsigned N           = 64;
    localparam int unsigned BLOCK_WORDS = 17;
    localparam int unsigned WCNT_W      = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        ABSORB  = 2'd2,
        SQUEEZE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/keccak_rr_pick.sv
// keccak_rr_pick: two-way round-robin pick. The requester that was not
// granted last wins a tie; with no previous grant (00) requester 0 wins.
module keccak_rr_pick (
    input  logic [1:0] i_req,
    input  logic [1:0] i_last_gnt,
    output logic [1:0] o_gnt
);

    logic w_prefer1;

    // Requester 1 is favoured only right after requester 0 held the core.
    assign w_prefer1 = i_last_gnt[0] & ~i_last_gnt[1];

    // One-hot pick; all zero when nobody requests.
    assign o_gnt[0] = i_req[0] & (~i_req[1] | ~w_prefer1);
    assign o_gnt[1] = i_req[1] & (~i_req[0] |  w_prefer1);

endmodule

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one keccak core between two requesters. A granted
// requester streams its message through ABSORB, then receives OUT_WORDS
// digest words in SQUEEZE before the core is released.
// Optional feature: define KECCAK_ARB_STATS_EN for per-requester completed
// message counters on Msg_count (tied to zero otherwise).
module keccak_arbiter
    import pkg_keccak::*;
#(
    parameter int unsigned OUT_WORDS = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [1:0]          Req_start,
    input  logic [1:0][N-1:0]   Req_din,
    input  logic [1:0]          Req_din_valid,
    input  logic [1:0]          Req_last_block,
    output logic [1:0]          Req_ready,
    output logic [1:0]          Grant,
    output logic [N-1:0]        Req_dout,
    output logic [1:0]          Req_dout_valid,
    output logic                Core_start,
    output logic                Core_din_valid,
    output logic                Core_last_block,
    output logic [N-1:0]        Core_din,
    input  logic                Core_buffer_full,
    input  logic                Core_ready,
    input  logic                Core_dout_valid,
    input  logic [N-1:0]        Core_dout,
    output logic [1:0][15:0]    Msg_count
);

    localparam int unsigned OCNT_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    arb_state_t          r_state;
    logic [1:0]          r_grant;
    logic [1:0]          r_last_gnt;
    logic                r_core_start;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic                r_blk_last;
    logic [OCNT_W-1:0]   r_out_cnt;

    logic [1:0]          w_pick;
    logic                w_owner;
    logic                w_absorb;
    logic                w_squeeze;
    logic                w_ready;
    logic                w_xfer;
    logic                w_own_last;
    logic                w_blk_end;
    logic                w_out_end;
    logic                w_msg_done;

    // Round-robin choice among pending starts.
    keccak_rr_pick u_pick (
        .i_req      (Req_start),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_pick)
    );

    // Owner index and phase decodes.
    assign w_owner    = r_grant[1];
    assign w_absorb   = (r_state == ABSORB);
    assign w_squeeze  = (r_state == SQUEEZE);
    assign w_ready    = w_absorb & ~Core_buffer_full;
    assign w_xfer     = w_ready & Req_din_valid[w_owner];
    assign w_own_last = Req_last_block[w_owner];
    assign w_blk_end  = (r_word_cnt == WCNT_W'(BLOCK_WORDS - 1));
    assign w_out_end  = (r_out_cnt == OCNT_W'(OUT_WORDS - 1));
    assign w_msg_done = w_squeeze & Core_dout_valid & w_out_end;

    // Datapath steering between the owner and the core.
    assign Grant           = r_grant;
    assign Core_start      = r_core_start;
    assign Req_ready       = r_grant & {2{w_ready}};
    assign Core_din_valid  = w_xfer;
    assign Core_din        = w_absorb ? Req_din[w_owner] : '0;
    assign Core_last_block = w_absorb & w_own_last;
    assign Req_dout        = w_squeeze ? Core_dout : '0;
    assign Req_dout_valid  = r_grant & {2{w_squeeze & Core_dout_valid}};

    // Arbitration FSM with block and digest word counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_gnt   <= '0;
            r_core_start <= 1'b0;
            r_word_cnt   <= '0;
            r_blk_last   <= 1'b0;
            r_out_cnt    <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Core_ready && (Req_start != 2'b00)) begin
                        r_grant      <= w_pick;
                        r_last_gnt   <= w_pick;
                        r_core_start <= 1'b1;
                        r_word_cnt   <= '0;
                        r_blk_last   <= 1'b0;
                        r_out_cnt    <= '0;
                        r_state      <= START;
                    end
                end
                START: begin
                    r_state <= ABSORB;
                end
                ABSORB: begin
                    if (w_xfer) begin
                        if (w_blk_end) begin
                            // Block boundary: finish if any word of this block was last.
                            r_word_cnt <= '0;
                            r_blk_last <= 1'b0;
                            if (r_blk_last || w_own_last) begin
                                r_state <= SQUEEZE;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + WCNT_W'(1);
                            r_blk_last <= r_blk_last | w_own_last;
                        end
                    end
                end
                SQUEEZE: begin
                    if (w_msg_done) begin
                        // Release; the next grant is decided from IDLE a cycle later.
                        r_out_cnt <= '0;
                        r_grant   <= '0;
                        r_state   <= IDLE;
                    end else if (Core_dout_valid) begin
                        r_out_cnt <= r_out_cnt + OCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef KECCAK_ARB_STATS_EN
    logic [1:0][15:0] r_msg_count;

    // Completed messages per requester; 16-bit wrap is intended.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_msg_count <= '0;
        end else if (w_msg_done) begin
            r_msg_count[w_owner] <= r_msg_count[w_owner] + 16'd1;
        end
    end

    assign Msg_count = r_msg_count;
`else
    assign Msg_count = '0;
`endif

endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: randomized and directed stimulus against a message-level
// reference model; every cycle's outputs are compared at the falling edge.
module tb_keccak_arbiter;
    import pkg_keccak::*;

    localparam int unsigned OUT_WORDS = 4;
    localparam int BW = 17;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [1:0]        Req_start;
    logic [1:0][N-1:0] Req_din;
    logic [1:0]        Req_din_valid;
    logic [1:0]        Req_last_block;
    logic [1:0]        Req_ready;
    logic [1:0]        Grant;
    logic [N-1:0]      Req_dout;
    logic [1:0]        Req_dout_valid;
    logic              Core_start;
    logic              Core_din_valid;
    logic              Core_last_block;
    logic [N-1:0]      Core_din;
    logic              Core_buffer_full;
    logic              Core_ready;
    logic              Core_dout_valid;
    logic [N-1:0]      Core_dout;
    logic [1:0][15:0]  Msg_count;

    keccak_arbiter #(.OUT_WORDS(OUT_WORDS)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Req_start       (Req_start),
        .Req_din         (Req_din),
        .Req_din_valid   (Req_din_valid),
        .Req_last_block  (Req_last_block),
        .Req_ready       (Req_ready),
        .Grant           (Grant),
        .Req_dout        (Req_dout),
        .Req_dout_valid  (Req_dout_valid),
        .Core_start      (Core_start),
        .Core_din_valid  (Core_din_valid),
        .Core_last_block (Core_last_block),
        .Core_din        (Core_din),
        .Core_buffer_full(Core_buffer_full),
        .Core_ready      (Core_ready),
        .Core_dout_valid (Core_dout_valid),
        .Core_dout       (Core_dout),
        .Msg_count       (Msg_count)
    );

    always #5 Clock = ~Clock;

    // Reference model: message-level view of who owns the core and how far along it is.
    int m_owner, m_words, m_last_blk, m_outs, m_prev, m_blocks, m_serial;
    bit m_start, m_last_all;
    int m_msgcnt [2];
    int msgs_left [2];

    // Stimulus knobs.
    int k_valid_pct, k_dv_pct, k_ready_pct, k_bf_mode, k_blocks, k_last_mode;
    bit k_refill, k_rst10, rst_pulse;
    int stall_left;

    // Event counters and grant order.
    int cnt_start, cnt_din, cnt_stall;
    int cnt_dv [2];
    int grant_log [$];

    int n_err, n_checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic bit m_squeezing();
        return (m_owner >= 0) && !m_start && (m_last_blk >= 0) && (m_words >= BW * (m_last_blk + 1));
    endfunction

    function automatic bit m_absorbing();
        return (m_owner >= 0) && !m_start && !m_squeezing();
    endfunction

    task automatic model_reset();
        m_owner = -1; m_start = 0; m_words = 0; m_last_blk = -1; m_outs = 0; m_prev = -1;
        m_msgcnt[0] = 0; m_msgcnt[1] = 0;
    endtask

    task automatic clear_counts();
        cnt_start = 0; cnt_din = 0; cnt_stall = 0; cnt_dv[0] = 0; cnt_dv[1] = 0;
        grant_log.delete();
    endtask

    task automatic drive_inputs();
        bit do_rst;
        do_rst = rst_pulse || (k_rst10 && m_absorbing() && m_words == 10);
        rst_pulse = 0;
        if (do_rst) begin
            k_rst10 = 0;
            Reset = 1'b1;
            model_reset();
        end else begin
            Reset = 1'b0;
        end
        for (int r = 0; r < 2; r++) begin
            if (k_refill && msgs_left[r] == 0 && m_owner != r && pct(3))
                msgs_left[r] = 1 + int'($urandom_range(1));
            if (m_owner == r) begin
                Req_start[r]      = 1'($urandom_range(1));
                Req_din[r]        = {8'(r), 24'(m_serial), 32'(m_words)};
                Req_last_block[r] = ((m_words / BW) == m_blocks - 1) &&
                                    (m_last_all || (m_words % BW) == BW - 1 || pct(20));
            end else begin
                Req_start[r]      = (msgs_left[r] > 0);
                Req_din[r]        = {$urandom, $urandom};
                Req_last_block[r] = 1'($urandom_range(1));
            end
            Req_din_valid[r] = pct(k_valid_pct);
        end
        Core_ready = pct(k_ready_pct);
        case (k_bf_mode)
            0: Core_buffer_full = pct(25);
            1: Core_buffer_full = 1'b0;
            default: begin
                if (m_absorbing() && m_words == 8 && stall_left > 0) begin
                    Core_buffer_full = 1'b1;
                    stall_left--;
                end else begin
                    Core_buffer_full = 1'b0;
                end
            end
        endcase
        Core_dout       = {$urandom, $urandom};
        Core_dout_valid = pct(k_dv_pct);
    endtask

    task automatic check_outputs();
        logic [1:0] g;
        bit ab, sq, xf;
        int oi;
        oi = (m_owner < 0) ? 0 : m_owner;
        ab = m_absorbing();
        sq = m_squeezing();
        g  = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        xf = ab && !Core_buffer_full && Req_din_valid[oi];
        chk("grant",          64'(Grant),           64'(g));
        chk("core_start",     64'(Core_start),      64'(m_owner >= 0 && m_start));
        chk("req_ready",      64'(Req_ready),       64'((ab && !Core_buffer_full) ? g : 2'b00));
        chk("core_din_valid", 64'(Core_din_valid),  64'(xf));
        chk("core_din",       64'(Core_din),        ab ? 64'(Req_din[oi]) : 64'd0);
        chk("core_last",      64'(Core_last_block), 64'(ab && Req_last_block[oi]));
        chk("req_dout",       64'(Req_dout),        sq ? 64'(Core_dout) : 64'd0);
        chk("req_dout_valid", 64'(Req_dout_valid),  64'((sq && Core_dout_valid) ? g : 2'b00));
`ifdef KECCAK_ARB_STATS_EN
        chk("msg_count0", 64'(Msg_count[0]), 64'(m_msgcnt[0]));
        chk("msg_count1", 64'(Msg_count[1]), 64'(m_msgcnt[1]));
`else
        chk("msg_count",  64'(Msg_count), 64'd0);
`endif
        if (Core_start) cnt_start++;
        if (Core_din_valid) cnt_din++;
        if (Req_dout_valid[0]) cnt_dv[0]++;
        if (Req_dout_valid[1]) cnt_dv[1]++;
        if (ab && Req_ready == 2'b00) cnt_stall++;
    endtask

    // Model state after the coming rising edge.
    task automatic advance_model();
        int p;
        if (Reset) return;
        if (m_owner < 0) begin
            if (Core_ready && Req_start != 2'b00) begin
                if (Req_start == 2'b11) p = (m_prev == 0) ? 1 : 0;
                else                    p = Req_start[1] ? 1 : 0;
                m_owner = p; m_prev = p; m_start = 1;
                m_words = 0; m_last_blk = -1; m_outs = 0; m_serial++;
                msgs_left[p]--;
                grant_log.push_back(p);
                m_blocks   = (k_blocks == 0) ? 1 + int'($urandom_range(1)) : k_blocks;
                m_last_all = (k_last_mode == 0) ? pct(50) : (k_last_mode == 1);
            end
        end else if (m_start) begin
            m_start = 0;
        end else if (m_absorbing()) begin
            if (!Core_buffer_full && Req_din_valid[m_owner]) begin
                if (Req_last_block[m_owner] && m_last_blk < 0) m_last_blk = m_words / BW;
                m_words++;
            end
        end else if (Core_dout_valid) begin
            m_outs++;
            if (m_outs == int'(OUT_WORDS)) begin
                m_msgcnt[m_owner] = (m_msgcnt[m_owner] + 1) & 16'hFFFF;
                m_owner = -1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
        drive_inputs();
        @(negedge Clock);
        check_outputs();
        advance_model();
    endtask

    task automatic do_reset();
        rst_pulse = 1;
        cycle();
        cycle();
    endtask

    task automatic run_until_idle(input string name);
        int n;
        bit busy;
        n = 0;
        do begin
            cycle();
            n++;
            busy = (m_owner >= 0) || msgs_left[0] > 0 || msgs_left[1] > 0;
        end while (busy && n < 4000);
        chk({name, "_finished"}, 64'(busy), 64'd0);
    endtask

    initial begin
        n_err = 0; n_checks = 0; m_serial = 0;
        msgs_left[0] = 0; msgs_left[1] = 0;
        Reset = 1'b1; Req_start = '0; Req_din = '0; Req_din_valid = '0; Req_last_block = '0;
        Core_buffer_full = 1'b0; Core_ready = 1'b0; Core_dout_valid = 1'b0; Core_dout = '0;
        model_reset();
        k_valid_pct = 100; k_dv_pct = 100; k_ready_pct = 100; k_bf_mode = 1;
        k_blocks = 1; k_last_mode = 1; k_refill = 0; k_rst10 = 0; stall_left = 0;
        clear_counts();

        // Reset state.
        rst_pulse = 1;
        cycle();
        chk("rst_grant",      64'(Grant), 64'd0);
        chk("rst_core_start", 64'(Core_start), 64'd0);
        chk("rst_req_ready",  64'(Req_ready), 64'd0);
        chk("rst_msg_count",  64'(Msg_count), 64'd0);
        cycle();

        // Single one-block message from requester 0.
        clear_counts();
        msgs_left[0] = 1;
        run_until_idle("single");
        cycle();
        chk("single_start_pulses", 64'(cnt_start), 64'd1);
        chk("single_words",        64'(cnt_din), 64'd17);
        chk("single_dout0",        64'(cnt_dv[0]), 64'd4);
        chk("single_dout1",        64'(cnt_dv[1]), 64'd0);
        chk("single_grant_count",  64'(grant_log.size()), 64'd1);
        chk("single_grant_after",  64'(Grant), 64'd0);

        // Both requesting together, twice: 0, 1, 0.
        do_reset();
        clear_counts();
        msgs_left[0] = 2; msgs_left[1] = 1;
        run_until_idle("rr");
        chk("rr_grants", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() == 3) begin
            chk("rr_first",  64'(grant_log[0]), 64'd0);
            chk("rr_second", 64'(grant_log[1]), 64'd1);
            chk("rr_third",  64'(grant_log[2]), 64'd0);
        end

        // Buffer full for five cycles after word 8.
        clear_counts();
        k_bf_mode = 2; stall_left = 5;
        msgs_left[0] = 1;
        run_until_idle("stall");
        chk("stall_cycles", 64'(cnt_stall), 64'd5);
        chk("stall_words",  64'(cnt_din), 64'd17);
        k_bf_mode = 1;

        // Two-block message from requester 1.
        clear_counts();
        k_blocks = 2;
        msgs_left[1] = 1;
        run_until_idle("twoblk");
        chk("twoblk_words", 64'(cnt_din), 64'd34);
        chk("twoblk_dout1", 64'(cnt_dv[1]), 64'd4);
        k_blocks = 1;

        // Reset during word 10, then a clean message.
        clear_counts();
        k_rst10 = 1;
        msgs_left[0] = 1;
        for (int i = 0; i < 200 && k_rst10; i++) cycle();
        chk("rst10_hit",          64'(k_rst10), 64'd0);
        chk("rst10_grant",        64'(Grant), 64'd0);
        chk("rst10_ready",        64'(Req_ready), 64'd0);
        chk("rst10_din_valid",    64'(Core_din_valid), 64'd0);
        chk("rst10_last",         64'(Core_last_block), 64'd0);
        chk("rst10_words_before", 64'(cnt_din), 64'd10);
        clear_counts();
        msgs_left[0] = 1;
        run_until_idle("after_rst");
        chk("after_rst_words", 64'(cnt_din), 64'd17);
        chk("after_rst_dout0", 64'(cnt_dv[0]), 64'd4);

        // Three messages from requester 1 for the statistics counters.
        do_reset();
        clear_counts();
        msgs_left[1] = 3;
        run_until_idle("stats");
`ifdef KECCAK_ARB_STATS_EN
        chk("stats_req1", 64'(Msg_count[1]), 64'd3);
`else
        chk("stats_req1", 64'(Msg_count[1]), 64'd0);
`endif
        chk("stats_req0", 64'(Msg_count[0]), 64'd0);

        // Randomized traffic.
        do_reset();
        clear_counts();
        k_valid_pct = 70; k_dv_pct = 50; k_ready_pct = 80; k_bf_mode = 0;
        k_blocks = 0; k_last_mode = 0; k_refill = 1;
        repeat (4000) cycle();
        k_refill = 0;
        run_until_idle("random");
        chk("random_activity", 64'(cnt_dv[0] > 0 && cnt_dv[1] > 0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
